// File: rtl/sparse_output_encoder.sv
// sparse_output_encoder: zero-value compression into packed nonzero bytes plus per-word nonzero masks.
// Optional ENCODER_STATS_EN adds per-tile encoded-word and zero-byte counters.
module sparse_output_encoder #(
    parameter int IO_DATA_WIDTH = 8,
    parameter int MEM_BW        = 128
) (
    input  logic              clk,
    input  logic              arst_n_in,
    input  logic [MEM_BW-1:0] dense_in,
    input  logic              dense_valid,
    output logic              dense_ready,
    input  logic              last_in,
    output logic [MEM_BW-1:0] out_encoded,
    output logic              output_valid_encoded,
    output logic [MEM_BW-1:0] out_masks,
    output logic              output_valid_masks
`ifdef ENCODER_STATS_EN
    ,
    output logic [15:0]       tile_encoded_words,
    output logic [31:0]       tile_zero_bytes
`endif
);
    localparam int LANES = MEM_BW / IO_DATA_WIDTH;
    localparam int MASKS_PER_WORD = MEM_BW / LANES;
    localparam int CW = $clog2(LANES + 1);
    localparam int FW = $clog2(LANES);
    localparam int GW = MASKS_PER_WORD > 1 ? $clog2(MASKS_PER_WORD) : 1;
    localparam int SW = CW + 1;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [2*MEM_BW-1:0] buf_q, merged;
    logic [FW-1:0]       fill_q;
    logic [GW-1:0]       grp_q;
    logic [MEM_BW-1:0]   acc_q, mask_merged, comp;
    logic [LANES-1:0]    mask;
    logic [CW-1:0]       cnt;
    logic [SW-1:0]       sum;
    logic                full, grp_full, accept;

    always_ff @(posedge clk or negedge arst_n_in)
        if (!arst_n_in) state_q <= RUN;
        else            state_q <= state_d;

    always_comb state_d = state_q == FLUSH ? RUN : (accept && last_in ? FLUSH : RUN);

    always_comb dense_ready = state_q == RUN;

    // Compact nonzero lanes toward byte 0; the buffer keeps bytes above fill at zero so OR-merge works.
    always_comb begin
        mask = '0;
        comp = '0;
        cnt  = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = |dense_in[i*IO_DATA_WIDTH +: IO_DATA_WIDTH];
            if (mask[i]) begin
                comp[int'(cnt)*IO_DATA_WIDTH +: IO_DATA_WIDTH] = dense_in[i*IO_DATA_WIDTH +: IO_DATA_WIDTH];
                cnt = cnt + 1'b1;
            end
        end
    end

    assign accept      = dense_valid && dense_ready;
    assign merged      = buf_q | ({{MEM_BW{1'b0}}, comp} << (int'(fill_q) * IO_DATA_WIDTH));
    assign mask_merged = acc_q | ({{(MEM_BW-LANES){1'b0}}, mask} << (int'(grp_q) * LANES));
    assign sum         = SW'(fill_q) + SW'(cnt);
    assign full        = sum >= SW'(LANES);
    assign grp_full    = grp_q == GW'(MASKS_PER_WORD - 1);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            buf_q                <= '0;
            fill_q               <= '0;
            grp_q                <= '0;
            acc_q                <= '0;
            out_encoded          <= '0;
            output_valid_encoded <= 1'b0;
            out_masks            <= '0;
            output_valid_masks   <= 1'b0;
        end else begin
            output_valid_encoded <= 1'b0;
            output_valid_masks   <= 1'b0;
            if (accept) begin
                if (full) begin
                    out_encoded          <= merged[MEM_BW-1:0];
                    output_valid_encoded <= 1'b1;
                    buf_q                <= {{MEM_BW{1'b0}}, merged[2*MEM_BW-1:MEM_BW]};
                    fill_q               <= FW'(sum - SW'(LANES));
                end else begin
                    buf_q  <= merged;
                    fill_q <= FW'(sum);
                end
                if (grp_full) begin
                    out_masks          <= mask_merged;
                    output_valid_masks <= 1'b1;
                    acc_q              <= '0;
                    grp_q              <= '0;
                end else begin
                    acc_q <= mask_merged;
                    grp_q <= grp_q + 1'b1;
                end
            end else if (state_q == FLUSH) begin
                if (fill_q != '0) begin
                    out_encoded          <= buf_q[MEM_BW-1:0];
                    output_valid_encoded <= 1'b1;
                    buf_q                <= '0;
                    fill_q               <= '0;
                end
                if (grp_q != '0) begin
                    out_masks          <= acc_q;
                    output_valid_masks <= 1'b1;
                    acc_q              <= '0;
                    grp_q              <= '0;
                end
            end
        end
    end

`ifdef ENCODER_STATS_EN
    logic [15:0] enc_run;
    logic [31:0] zero_run;
    logic [32:0] zsum;

    assign zsum = {1'b0, zero_run} + 33'(LANES - int'(cnt));

    // Running tile counts are published and cleared in the FLUSH cycle, counting the residual word.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            enc_run            <= '0;
            zero_run           <= '0;
            tile_encoded_words <= '0;
            tile_zero_bytes    <= '0;
        end else if (accept) begin
            zero_run <= zsum[32] ? '1 : zsum[31:0];
            if (full && enc_run != '1) enc_run <= enc_run + 1'b1;
        end else if (state_q == FLUSH) begin
            tile_encoded_words <= (fill_q != '0 && enc_run != '1) ? enc_run + 1'b1 : enc_run;
            tile_zero_bytes    <= zero_run;
            enc_run            <= '0;
            zero_run           <= '0;
        end
    end
`endif
endmodule
